// File: rtl/instr_mem_responder_pkg.sv
// instr_mem_responder_pkg: shared constants, responder states and address check
package instr_mem_responder_pkg;
  localparam logic [31:0] IMEM_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, RESP = 2'b10} state_t;
  function automatic logic addr_err(input logic [31:0] a, input logic [31:0] base, input int unsigned depth);
    logic [32:0] lo, hi;
    lo = {1'b0, base};
    hi = lo + (33'(depth) << 2);
    return (a[1:0] != 2'b00) || ({1'b0, a} < lo) || ({1'b0, a} >= hi);
  endfunction
endpackage

// File: rtl/instr_mem_responder_imem_array.sv
// imem_array: single-read single-write word RAM, read registered on enable
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [31:0]   rd_data_o,
  input  logic          we_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [31:0]   wr_data_i
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk_i)
    if (!rst_i) rd_data_o <= '0;
    else if (rd_en_i) rd_data_o <= mem[rd_idx_i];
  always_ff @(posedge clk_i)
    if (we_i) mem[wr_idx_i] <= wr_data_i;
endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: fixed-latency single-outstanding instruction fetch responder
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic        resp_error_o,
  output logic        busy_o,
  input  logic        load_en_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state;
  logic [3:0] cnt;
  logic err_q, accept;
  logic [31:0] rd_data;
  assign req_ready_o = (state == IDLE) && rst_i;
  assign accept = req_valid_i && req_ready_o;
  assign resp_valid_o = state == RESP;
  assign busy_o = state != IDLE;
  assign resp_error_o = err_q;
  assign resp_data_o = err_q ? RV_NOP : rd_data;
  imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .rd_en_i(accept),
    .rd_idx_i(AW'((req_addr_i - BASE_ADDR) >> 2)),
    .rd_data_o(rd_data),
    .we_i(load_en_i && !addr_err(load_addr_i, BASE_ADDR, DEPTH_WORDS)),
    .wr_idx_i(AW'((load_addr_i - BASE_ADDR) >> 2)),
    .wr_data_i(load_data_i)
  );
  // RESP is entered on the edge where cnt reaches 0, so valid is sampled high LATENCY edges after accept
  always_ff @(posedge clk_i)
    if (!rst_i) begin
      state <= IDLE;
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          err_q <= addr_err(req_addr_i, BASE_ADDR, DEPTH_WORDS);
          cnt <= 4'(LATENCY - 1);
          state <= (LATENCY == 1) ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= RESP;
        end
        RESP: if (resp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: directed checks on LATENCY=2 and LATENCY=1 responders
module tb_instr_mem_responder;
  logic clk = 0, rst = 0;
  logic load_en = 0;
  logic [31:0] load_addr = 0, load_data = 0;
  logic v2 = 0, rr2 = 0, v1 = 0, rr1 = 0;
  logic [31:0] a2 = 0, a1 = 0;
  logic req_ready2, resp_valid2, resp_error2, busy2;
  logic req_ready1, resp_valid1, resp_error1, busy1;
  logic [31:0] resp_data2, resp_data1;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(.LATENCY(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v2), .req_addr_i(a2), .req_ready_o(req_ready2),
    .resp_valid_o(resp_valid2), .resp_ready_i(rr2), .resp_data_o(resp_data2),
    .resp_error_o(resp_error2), .busy_o(busy2), .load_en_i(load_en),
    .load_addr_i(load_addr), .load_data_i(load_data));

  instr_mem_responder #(.LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v1), .req_addr_i(a1), .req_ready_o(req_ready1),
    .resp_valid_o(resp_valid1), .resp_ready_i(rr1), .resp_data_o(resp_data1),
    .resp_error_o(resp_error1), .busy_o(busy1), .load_en_i(load_en),
    .load_addr_i(load_addr), .load_data_i(load_data));

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 0;
  endtask

  task automatic req2(input logic [31:0] a, output bit got);
    @(negedge clk);
    v2 = 1; a2 = a;
    @(negedge clk);
    v2 = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid2) begin got = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic done2;
    rr2 = 1;
    @(negedge clk);
    rr2 = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++; if (req_ready2 !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", req_ready2); end
    checks++; if ({resp_valid2, resp_error2, busy2} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {resp_valid2, resp_error2, busy2}); end
    checks++; if (resp_data2 !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", resp_data2); end
    rst = 1;
    #1;
    checks++; if (req_ready2 !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", req_ready2); end
  endtask

  task automatic test_aligned;
    load(32'h8000_0000, 32'h0050_0093);
    @(negedge clk);
    v2 = 1; a2 = 32'h8000_0000;
    @(negedge clk);
    v2 = 0;
    checks++; if ({resp_valid2, busy2} !== 2'b01) begin errors++; $display("FAIL lat_cycle1 valid,busy got=%b exp=01", {resp_valid2, busy2}); end
    @(negedge clk);
    checks++; if ({resp_valid2, busy2, resp_error2} !== 3'b110) begin errors++; $display("FAIL lat_cycle2 valid,busy,err got=%b exp=110", {resp_valid2, busy2, resp_error2}); end
    checks++; if (resp_data2 !== 32'h0050_0093) begin errors++; $display("FAIL aligned_data got=%h exp=00500093", resp_data2); end
    done2;
    checks++; if ({resp_valid2, busy2} !== 2'b00) begin errors++; $display("FAIL after_handshake got=%b exp=00", {resp_valid2, busy2}); end
    checks++; if (resp_data2 !== 32'h0050_0093) begin errors++; $display("FAIL data_hold got=%h exp=00500093", resp_data2); end
  endtask

  task automatic test_backpressure;
    bit got;
    req2(32'h8000_0000, got);
    checks++; if (!got) begin errors++; $display("FAIL bp_timeout got=no_resp exp=resp"); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({resp_valid2, req_ready2, resp_error2} !== 3'b100 || resp_data2 !== 32'h0050_0093) begin
        errors++; $display("FAIL bp_hold%0d valid,ready,err=%b data=%h exp=100 00500093", i, {resp_valid2, req_ready2, resp_error2}, resp_data2);
      end
    end
    done2;
    checks++; if ({resp_valid2, req_ready2} !== 2'b01) begin errors++; $display("FAIL bp_release valid,ready got=%b exp=01", {resp_valid2, req_ready2}); end
  endtask

  task automatic test_errors;
    logic [31:0] addrs [4];
    logic [31:0] exp_d [4];
    logic exp_e [4];
    bit got;
    addrs = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_1000, 32'h8000_0FFC};
    exp_d = '{32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 32'hDEAD_BEEF};
    exp_e = '{1'b1, 1'b1, 1'b1, 1'b0};
    load(32'h8000_0FFC, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      req2(addrs[i], got);
      checks++; if (!got || resp_error2 !== exp_e[i] || resp_data2 !== exp_d[i]) begin
        errors++; $display("FAIL err_addr %h got resp=%0d err=%b data=%h exp err=%b data=%h", addrs[i], got, resp_error2, resp_data2, exp_e[i], exp_d[i]);
      end
      done2;
    end
  endtask

  task automatic test_reset_mid;
    bit got, seen;
    load(32'h8000_0004, 32'h1234_5678);
    @(negedge clk);
    v2 = 1; a2 = 32'h8000_0004;
    @(negedge clk);
    v2 = 0; rst = 0;
    @(negedge clk);
    rst = 1;
    checks++; if ({resp_valid2, busy2} !== 2'b00) begin errors++; $display("FAIL mid_reset valid,busy got=%b exp=00", {resp_valid2, busy2}); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid2) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL dropped_resp got=seen exp=none"); end
    req2(32'h8000_0004, got);
    checks++; if (!got || resp_data2 !== 32'h1234_5678 || resp_error2 !== 1'b0) begin
      errors++; $display("FAIL post_reset_read got resp=%0d data=%h err=%b exp data=12345678 err=0", got, resp_data2, resp_error2);
    end
    done2;
  endtask

  task automatic test_collision;
    bit got;
    load(32'h8000_0004, 32'hAAAA_AAAA);
    @(negedge clk);
    v2 = 1; a2 = 32'h8000_0004;
    load_en = 1; load_addr = 32'h8000_0004; load_data = 32'h5555_5555;
    @(negedge clk);
    v2 = 0; load_en = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (resp_valid2) got = 1;
      else @(negedge clk);
    end
    checks++; if (!got || resp_data2 !== 32'hAAAA_AAAA) begin errors++; $display("FAIL collision_old got resp=%0d data=%h exp=aaaaaaaa", got, resp_data2); end
    done2;
    req2(32'h8000_0004, got);
    checks++; if (!got || resp_data2 !== 32'h5555_5555) begin errors++; $display("FAIL collision_new got resp=%0d data=%h exp=55555555", got, resp_data2); end
    done2;
  endtask

  task automatic test_back_to_back;
    logic [31:0] words [4];
    int k, c;
    words = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    for (int i = 0; i < 4; i++) load(32'h8000_0008 + 32'(4 * i), words[i]);
    @(negedge clk);
    v1 = 1; rr1 = 1; a1 = 32'h8000_0008;
    k = 0; c = 0;
    while (k < 4 && c < 20) begin
      @(negedge clk);
      checks++; if (resp_valid1 !== ((c % 2) == 0)) begin errors++; $display("FAIL b2b_valid cycle %0d got=%b exp=%b", c, resp_valid1, (c % 2) == 0); end
      if (resp_valid1) begin
        checks++; if (resp_data1 !== words[k] || resp_error1 !== 1'b0) begin errors++; $display("FAIL b2b_data %0d got=%h err=%b exp=%h", k, resp_data1, resp_error1, words[k]); end
        k++;
        a1 = 32'h8000_0008 + 32'(4 * k);
        if (k == 4) v1 = 0;
      end
      c++;
    end
    checks++; if (k != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", k); end
    @(negedge clk);
    rr1 = 0;
    checks++; if ({resp_valid1, busy1, req_ready1} !== 3'b001) begin errors++; $display("FAIL b2b_idle got=%b exp=001", {resp_valid1, busy1, req_ready1}); end
  endtask

  initial begin
    test_reset;
    test_aligned;
    test_backpressure;
    test_errors;
    test_reset_mid;
    test_collision;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
